// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction memory,
// and buffers {pc, instr} pairs in a 2-entry queue that feeds decode over valid/ready.
module fetch_unit #(
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           ADDRESS_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     PCsrc,
  input  logic                     JumpReg,
  input  logic [DATA_WIDTH-1:0]    redirect_base,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  input  logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_pc,
  output logic [DATA_WIDTH-1:0]    out_instr
);

  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] q_pc    [2];
  logic [DATA_WIDTH-1:0] q_instr [2];
  logic                  head;
  logic                  tail;
  logic [1:0]            count;

  logic                  pop;
  logic                  push;
  logic [DATA_WIDTH-1:0] target_raw;
  logic [DATA_WIDTH-1:0] target;

  assign mem_addr  = fetch_pc[ADDRESS_WIDTH-1:0];
  assign out_valid = (count != 2'd0);
  assign out_pc    = q_pc[head];
  assign out_instr = q_instr[head];

  // A full queue may still accept a push when the head leaves in the same cycle.
  assign pop  = out_valid & out_ready;
  assign push = fetch_en & ~PCsrc & ((count < 2'd2) | pop);

  always_comb begin
    target_raw = JumpReg ? ALUResult : (redirect_base + ImmOp);
    target     = {target_raw[DATA_WIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= 1'b0;
      tail     <= 1'b0;
      count    <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (PCsrc) begin
      // Redirect flushes everything; a concurrent pop simply completes.
      fetch_pc <= target;
      head     <= 1'b0;
      tail     <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        q_pc[tail]    <= fetch_pc;
        q_instr[tail] <= mem_rdata;
        tail          <= tail + 1'b1;
        fetch_pc      <= fetch_pc + DATA_WIDTH'(4);
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; instruction memory returns its own byte address.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        PCsrc;
  logic        JumpReg;
  logic [31:0] redirect_base;
  logic [31:0] ImmOp;
  logic [31:0] ALUResult;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int errors = 0;
  int checks = 0;

  fetch_unit #(
    .DATA_WIDTH   (32),
    .ADDRESS_WIDTH(8),
    .RESET_PC     (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .PCsrc        (PCsrc),
    .JumpReg      (JumpReg),
    .redirect_base(redirect_base),
    .ImmOp        (ImmOp),
    .ALUResult    (ALUResult),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr)
  );

  always #5 clk = ~clk;

  assign mem_rdata = {24'h0, mem_addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Head entry check: valid, pc, and instruction (low address byte of pc).
  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, out_instr, {24'h0, pc[7:0]});
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; PCsrc = 1'b0; JumpReg = 1'b0;
    redirect_base = '0; ImmOp = '0; ALUResult = '0;
    #2;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_addr", {24'h0, mem_addr}, 32'h0);
    tick(); tick();

    // Streaming with decode always ready.
    rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    chk("s_pre_valid", {31'h0, out_valid}, 32'h0);
    tick(); chk_head("s0", 32'h0);
    tick(); chk_head("s1", 32'h4);
    tick(); chk_head("s2", 32'h8);
    tick(); chk_head("s3", 32'hC);

    // Backpressure from reset: queue saturates at two entries.
    #2 rst = 1'b1;
    #1 chk("r2_valid", {31'h0, out_valid}, 32'h0);
    chk("r2_addr", {24'h0, mem_addr}, 32'h0);
    tick();
    rst = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk_head("bp2", 32'h0);
    chk("bp2_addr", {24'h0, mem_addr}, 32'h8);
    tick(); tick(); tick();
    chk_head("bp5", 32'h0);
    chk("bp5_addr", {24'h0, mem_addr}, 32'h8);
    out_ready = 1'b1;
    chk_head("dr0", 32'h0);
    tick(); chk_head("dr1", 32'h4);
    chk("dr1_addr", {24'h0, mem_addr}, 32'hC);
    tick(); chk_head("dr2", 32'h8);
    chk("dr2_addr", {24'h0, mem_addr}, 32'h10);
    // Drain with fetch off: exactly two entries remain.
    fetch_en = 1'b0;
    tick(); chk_head("dn0", 32'hC);
    chk("dn0_addr", {24'h0, mem_addr}, 32'h10);
    tick(); chk("dn1_valid", {31'h0, out_valid}, 32'h0);

    // Branch backwards while 0x14 sits behind the popped head.
    fetch_en = 1'b1; out_ready = 1'b0;
    tick(); tick();
    chk_head("br_head", 32'h10);
    out_ready = 1'b1; PCsrc = 1'b1; JumpReg = 1'b0;
    redirect_base = 32'h10; ImmOp = 32'hFFFF_FFF8;
    tick();
    PCsrc = 1'b0;
    chk("br_bubble", {31'h0, out_valid}, 32'h0);
    chk("br_addr", {24'h0, mem_addr}, 32'h8);
    tick(); chk_head("br_tgt", 32'h8);

    // JALR target with low bits forced clear.
    PCsrc = 1'b1; JumpReg = 1'b1; ALUResult = 32'h0000_0043;
    tick();
    PCsrc = 1'b0;
    chk("jr_bubble", {31'h0, out_valid}, 32'h0);
    chk("jr_addr", {24'h0, mem_addr}, 32'h40);
    tick(); chk_head("jr_tgt", 32'h40);

    // Redirect to the top of the address space, then PC wraps to zero.
    PCsrc = 1'b1; JumpReg = 1'b0; redirect_base = 32'h8; ImmOp = 32'hFFFF_FFF6;
    tick();
    PCsrc = 1'b0;
    chk("wr_addr", {24'h0, mem_addr}, 32'hFC);
    tick(); chk_head("wr_top", 32'hFFFF_FFFC);
    chk("wr_addr0", {24'h0, mem_addr}, 32'h0);
    tick(); chk_head("wr_zero", 32'h0);

    // fetch_en low: pops continue, PC holds.
    fetch_en = 1'b0;
    tick(); chk("hold_valid", {31'h0, out_valid}, 32'h0);
    chk("hold_addr", {24'h0, mem_addr}, 32'h4);
    tick(); chk("hold_addr2", {24'h0, mem_addr}, 32'h4);

    // Mid-stream reset with two entries queued.
    fetch_en = 1'b1; out_ready = 1'b0;
    tick(); tick();
    chk_head("mr_full", 32'h4);
    #2 rst = 1'b1;
    #1 chk("mr_valid", {31'h0, out_valid}, 32'h0);
    chk("mr_pc", out_pc, 32'h0);
    chk("mr_instr", out_instr, 32'h0);
    chk("mr_addr", {24'h0, mem_addr}, 32'h0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    chk("mr_pre_valid", {31'h0, out_valid}, 32'h0);
    tick(); chk_head("mr0", 32'h0);
    tick(); chk_head("mr1", 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
